// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared constants and types for the 3x3 median stream filter
package median_pkg;
  localparam int DATA_W   = 8;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int LATENCY  = 4;

  typedef logic [DATA_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t lo;
    pixel_t mid;
    pixel_t hi;
  } col_t;
endpackage

// File: rtl/sort3.sv
// rtl/sort3.sv - combinational three-input sorter (lo/mid/hi), unsigned
module sort3
  import median_pkg::*;
(
  input  pixel_t a,
  input  pixel_t b,
  input  pixel_t c,
  output col_t   col
);
  pixel_t lo_ab;
  pixel_t hi_ab;

  assign lo_ab   = (a < b) ? a : b;
  assign hi_ab   = (a < b) ? b : a;
  assign col.lo  = (c < lo_ab) ? c : lo_ab;
  assign col.hi  = (c > hi_ab) ? c : hi_ab;
  assign col.mid = (c < lo_ab) ? lo_ab : ((c > hi_ab) ? hi_ab : c);
endmodule

// File: rtl/median3x3_stream.sv
// rtl/median3x3_stream.sv - streaming 3x3 median filter, 4-stage pipeline
// Optional MEDIAN_BYPASS_EN adds i_bypass to pass the raw centre pixel.
module median3x3_stream
  import median_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [X_W-1:0]    i_x,
  input  logic [Y_W-1:0]    i_y,
  input  logic [DATA_W-1:0] i_pix,
`ifdef MEDIAN_BYPASS_EN
  input  logic              i_bypass,
`endif
  output logic              o_valid,
  output logic [X_W-1:0]    o_x,
  output logic [Y_W-1:0]    o_y,
  output logic [DATA_W-1:0] o_pix
);
  logic bp_in;
`ifdef MEDIAN_BYPASS_EN
  assign bp_in = i_bypass;
`else
  assign bp_in = 1'b0;
`endif

  pixel_t lb0 [H_ACTIVE];
  pixel_t lb1 [H_ACTIVE];
  pixel_t rd0, rd1;

  logic           v1, bp1;
  logic [X_W-1:0] x1;
  logic [Y_W-1:0] y1;
  pixel_t         p1;

  // Read-first RAMs; lb1 is fed from lb0's read data one cycle later.
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      rd0      <= lb0[i_x];
      rd1      <= lb1[i_x];
      lb0[i_x] <= i_pix;
    end
    if (v1) lb1[x1] <= rd0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1  <= 1'b0;
      bp1 <= 1'b0;
      x1  <= '0;
      y1  <= '0;
      p1  <= '0;
    end else begin
      v1  <= i_valid;
      bp1 <= bp_in;
      x1  <= i_x;
      y1  <= i_y;
      p1  <= i_pix;
    end
  end

  col_t col_new;
  sort3 u_col (.a(rd1), .b(rd0), .c(p1), .col(col_new));

  col_t           w0, w1, w2;
  pixel_t         prev_c, c2;
  logic           v2, raw2;
  logic [X_W-1:0] x2;
  logic [Y_W-1:0] y2;

  // The centre is the lb0 pixel of the column before the one being shifted in.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v2     <= 1'b0;
      raw2   <= 1'b0;
      x2     <= '0;
      y2     <= '0;
      w0     <= '0;
      w1     <= '0;
      w2     <= '0;
      prev_c <= '0;
      c2     <= '0;
    end else begin
      v2   <= v1 && (x1 != '0) && (y1 != '0);
      raw2 <= (x1 == X_W'(1)) || (y1 == Y_W'(1)) || bp1;
      x2   <= x1 - 1'b1;
      y2   <= y1 - 1'b1;
      if (v1) begin
        w2     <= w1;
        w1     <= w0;
        w0     <= col_new;
        prev_c <= rd0;
        c2     <= prev_c;
      end
    end
  end

  col_t s_lo, s_mid, s_hi;
  sort3 u_lo  (.a(w0.lo),  .b(w1.lo),  .c(w2.lo),  .col(s_lo));
  sort3 u_mid (.a(w0.mid), .b(w1.mid), .c(w2.mid), .col(s_mid));
  sort3 u_hi  (.a(w0.hi),  .b(w1.hi),  .c(w2.hi),  .col(s_hi));

  pixel_t         a3, b3, cc3, c3;
  logic           v3, raw3;
  logic [X_W-1:0] x3;
  logic [Y_W-1:0] y3;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v3   <= 1'b0;
      raw3 <= 1'b0;
      x3   <= '0;
      y3   <= '0;
      a3   <= '0;
      b3   <= '0;
      cc3  <= '0;
      c3   <= '0;
    end else begin
      v3   <= v2;
      raw3 <= raw2;
      x3   <= x2;
      y3   <= y2;
      a3   <= s_lo.hi;
      b3   <= s_mid.mid;
      cc3  <= s_hi.lo;
      c3   <= c2;
    end
  end

  col_t s_med;
  sort3 u_med (.a(a3), .b(b3), .c(cc3), .col(s_med));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_pix   <= '0;
    end else begin
      o_valid <= v3;
      o_x     <= x3;
      o_y     <= y3;
      o_pix   <= raw3 ? c3 : s_med.mid;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{s_lo.lo, s_lo.mid, s_mid.lo, s_mid.hi,
                         s_hi.mid, s_hi.hi, s_med.lo, s_med.hi};
endmodule

// File: tb/tb_median3x3_stream.sv
// tb/tb_median3x3_stream.sv - scoreboard bench for median3x3_stream
module tb_median3x3_stream;
  import median_pkg::*;

  localparam int K_FLAT = 0;
  localparam int K_IMP  = 1;
  localparam int K_RAMP = 2;
  localparam int K_WIN  = 3;
  // Output is registered on the 4th edge counting the input sample edge.
  localparam int PIPE_EDGES = LATENCY - 1;
`ifdef MEDIAN_BYPASS_EN
  localparam int BYP_PIX = 255;
`else
  localparam int BYP_PIX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        bypass = 1'b0;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic [7:0]  pix = '0;
  logic        o_valid;
  logic [9:0]  o_x;
  logic [8:0]  o_y;
  logic [7:0]  o_pix;

  median3x3_stream dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .i_x     (x),
    .i_y     (y),
    .i_pix   (pix),
`ifdef MEDIAN_BYPASS_EN
    .i_bypass(bypass),
`endif
    .o_valid (o_valid),
    .o_x     (o_x),
    .o_y     (o_y),
    .o_pix   (o_pix)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ox;
    int oy;
    int pix;
    bit known;
    int stamp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int n_out = 0;
  int win_tab [3][3] = '{'{1, 9, 2}, '{8, 3, 7}, '{4, 6, 5}};

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int src(int kind, int xx, int yy);
    case (kind)
      K_FLAT:  return 100;
      K_IMP:   return (xx == 10 && yy == 10) ? 255 : 0;
      K_RAMP:  return xx % 256;
      default: return win_tab[yy-49][xx-49];
    endcase
  endfunction

  // Values are only asserted where the whole window lies inside the driven block.
  function automatic exp_t mk_exp(int kind, int xx, int yy, int x0, int y0);
    exp_t e;
    e.ox = xx - 1;
    e.oy = yy - 1;
    e.stamp = cyc + 1;
    if (e.ox == 0 || e.oy == 0) e.known = (xx >= x0 + 1) && (yy >= y0 + 1);
    else                        e.known = (xx >= x0 + 2) && (yy >= y0 + 2);
    case (kind)
      K_FLAT:  e.pix = 100;
      K_IMP:   e.pix = (e.ox == 10 && e.oy == 10) ? BYP_PIX : 0;
      K_RAMP:  e.pix = e.ox % 256;
      default: begin
        e.pix = 5;
        e.known = (e.ox == 50 && e.oy == 50);
      end
    endcase
    return e;
  endfunction

  task automatic send(int kind, int xx, int yy, int x0, int y0);
    @(negedge clk);
    valid  = 1'b1;
    x      = xx[9:0];
    y      = yy[8:0];
    pix    = 8'(src(kind, xx, yy));
    bypass = (kind == K_IMP && xx == 11 && yy == 11);
    if (xx >= 1 && yy >= 1) sb.push_back(mk_exp(kind, xx, yy, x0, y0));
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      valid  = 1'b0;
      bypass = 1'b0;
    end
  endtask

  task automatic drive(int kind, int x0, int x1, int y0, int y1, int gap_x);
    for (int yy = y0; yy <= y1; yy++) begin
      for (int xx = x0; xx <= x1; xx++) begin
        if (xx == gap_x) idle(2);
        send(kind, xx, yy, x0, y0);
      end
      idle(3);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (o_valid === 1'b1) begin
        n_out++;
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("o_x", int'(o_x), e.ox);
          check("o_y", int'(o_y), e.oy);
          check("latency", cyc - e.stamp, PIPE_EDGES);
          if (e.known) check("o_pix", int'(o_pix), e.pix);
        end
      end
    end
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check("reset_o_valid", int'(o_valid), 0);
    check("reset_o_pix", int'(o_pix), 0);
    check("reset_o_x", int'(o_x), 0);
    check("reset_o_y", int'(o_y), 0);
    rst = 1'b0;
    idle(2);

    base = n_out;
    drive(K_FLAT, 0, 11, 0, 5, 6);
    idle(8);
    check("flat_count", n_out - base, 55);

    base = n_out;
    drive(K_IMP, 0, 13, 0, 13, -1);
    idle(8);
    check("impulse_count", n_out - base, 169);

    drive(K_RAMP, 0, 7, 0, 7, 4);
    drive(K_RAMP, 196, 204, 97, 101, 200);
    drive(K_RAMP, 632, 639, 0, 3, -1);
    drive(K_WIN, 49, 51, 49, 51, -1);
    idle(8);

    for (int xx = 295; xx <= 299; xx++) send(K_RAMP, xx, 20, 295, 20);
    @(negedge clk);
    valid = 1'b1;
    x     = 10'd300;
    y     = 9'd20;
    pix   = 8'(src(K_RAMP, 300, 20));
    rst   = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midreset_o_valid", int'(o_valid), 0);
    check("midreset_o_pix", int'(o_pix), 0);
    check("midreset_o_x", int'(o_x), 0);
    check("midreset_o_y", int'(o_y), 0);
    rst   = 1'b0;
    valid = 1'b0;
    drive(K_RAMP, 301, 310, 20, 21, -1);
    check("no_x_outputs", int'($isunknown({o_valid, o_x, o_y, o_pix})), 0);

    idle(10);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
